// File: rtl/pr3_fft_sched.sv
// pr3_fft_sched: frame scheduler sharing one two-input FFT/phase core
// between NSINK ADC channels (reference channel 0 vs rotating partner k).
//
// Ports:
//   clk40, reset_n      clock, async active-low reset
//   enable              gates new frame starts (running frame completes)
//   sink                NSINK packed signed samples, channel i at [i*WIDTH +: WIDTH]
//   fft_ready           core can accept beats
//   fft_valid/sop/eop   Avalon-ST beat qualifiers to the core
//   fft_dataA/B         channel-0 / channel-k samples
//   fft_pair            partner k of current/last packet
//   res_valid/res_eop   core result stream (only the last beat matters)
//   busy                scheduler not idle
//   frame_cnt           completed frames (wraps)
//   miss_cnt            ticks dropped while busy (saturating)
//   abort_cnt           packets cut short by fft_ready loss (saturating)
//   timeout_cnt         WAIT_RES watchdog expiries (saturating), present only
//                       when PR3_SCHED_TIMEOUT_EN is defined
module pr3_fft_sched #(
    parameter int NSINK = 3,
    parameter int WIDTH = 14,
    parameter int FFT   = 11,
    parameter int FREQ  = 5000,
    parameter int CLKHZ = 40000000
) (
    input  logic                       clk40,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [NSINK*WIDTH-1:0]     sink,
    input  logic                       fft_ready,
    output logic                       fft_valid,
    output logic                       fft_sop,
    output logic                       fft_eop,
    output logic [WIDTH-1:0]           fft_dataA,
    output logic [WIDTH-1:0]           fft_dataB,
    output logic [$clog2(NSINK)-1:0]   fft_pair,
    input  logic                       res_valid,
    input  logic                       res_eop,
    output logic                       busy,
    output logic [15:0]                frame_cnt,
    output logic [15:0]                miss_cnt,
    output logic [7:0]                 abort_cnt
`ifdef PR3_SCHED_TIMEOUT_EN
    ,
    output logic [7:0]                 timeout_cnt
`endif
);

    localparam int PERIOD = CLKHZ / FREQ;
    localparam int CW     = $clog2(PERIOD);
    localparam int PW     = $clog2(NSINK);

    typedef enum logic [1:0] {IDLE, ARM, STREAM, WAIT_RES} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   k_q;
    logic [FFT-1:0]  n_q;
    logic            tick;
    logic [PW-1:0]   k_d;

`ifdef PR3_SCHED_TIMEOUT_EN
    // Watchdog spans 4 frame lengths; expires when all bits are set.
    logic [FFT+1:0]  wd_q;
`endif

    assign tick = (cnt_q == CW'(PERIOD - 1));
    assign k_d  = (k_q == PW'(NSINK - 1)) ? PW'(1) : k_q + PW'(1);

    always_ff @(posedge clk40 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            k_q       <= PW'(1);
            n_q       <= '0;
            fft_valid <= 1'b0;
            fft_sop   <= 1'b0;
            fft_eop   <= 1'b0;
            fft_dataA <= '0;
            fft_dataB <= '0;
            fft_pair  <= PW'(1);
            busy      <= 1'b0;
            frame_cnt <= '0;
            miss_cnt  <= '0;
            abort_cnt <= '0;
`ifdef PR3_SCHED_TIMEOUT_EN
            wd_q        <= '0;
            timeout_cnt <= '0;
`endif
        end else begin
            cnt_q     <= tick ? '0 : cnt_q + 1'b1;
            fft_valid <= 1'b0;
            fft_sop   <= 1'b0;
            fft_eop   <= 1'b0;

            // Ticks are never queued: any tick seen outside IDLE is lost.
            if (tick && state_q != IDLE && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;

            unique case (state_q)
                IDLE: begin
                    if (tick && enable) begin
                        state_q  <= ARM;
                        busy     <= 1'b1;
                        fft_pair <= k_q;
                    end
                end
                ARM: begin
                    if (fft_ready) begin
                        state_q <= STREAM;
                        n_q     <= '0;
                    end
                end
                STREAM: begin
                    // The ADC cannot stall: a ready drop closes the packet
                    // on the beat being registered now.
                    fft_valid <= 1'b1;
                    fft_sop   <= (n_q == '0);
                    fft_eop   <= (&n_q) | ~fft_ready;
                    fft_dataA <= sink[WIDTH-1:0];
                    fft_dataB <= sink[fft_pair*WIDTH +: WIDTH];
                    n_q       <= n_q + 1'b1;
                    if (!fft_ready) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        if (abort_cnt != 8'hFF)
                            abort_cnt <= abort_cnt + 8'd1;
                    end else if (&n_q) begin
                        state_q <= WAIT_RES;
`ifdef PR3_SCHED_TIMEOUT_EN
                        wd_q    <= '0;
`endif
                    end
                end
                WAIT_RES: begin
                    if (res_valid && res_eop) begin
                        state_q   <= IDLE;
                        busy      <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                        k_q       <= k_d;
                    end
`ifdef PR3_SCHED_TIMEOUT_EN
                    else if (&wd_q) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        k_q     <= k_d;
                        if (timeout_cnt != 8'hFF)
                            timeout_cnt <= timeout_cnt + 8'd1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pr3_fft_sched.sv
// tb_pr3_fft_sched: directed self-checking bench for pr3_fft_sched
// (NSINK=3, FFT=4, PERIOD=100).
`timescale 1ns/1ps
module tb_pr3_fft_sched;

    localparam int NSINK = 3;
    localparam int WIDTH = 14;
    localparam int FFT   = 4;
    localparam int FREQ  = 10;
    localparam int CLKHZ = 1000;

    logic                   clk40 = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   enable = 1'b1;
    logic [NSINK*WIDTH-1:0] sink;
    logic                   fft_ready = 1'b1;
    logic                   fft_valid, fft_sop, fft_eop;
    logic [WIDTH-1:0]       fft_dataA, fft_dataB;
    logic [1:0]             fft_pair;
    logic                   res_valid = 1'b0;
    logic                   res_eop = 1'b0;
    logic                   busy;
    logic [15:0]            frame_cnt, miss_cnt;
    logic [7:0]             abort_cnt;
`ifdef PR3_SCHED_TIMEOUT_EN
    logic [7:0]             timeout_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [13:0] ramp = 14'd0;
    logic [13:0] neg;

    pr3_fft_sched #(
        .NSINK(NSINK), .WIDTH(WIDTH), .FFT(FFT), .FREQ(FREQ), .CLKHZ(CLKHZ)
    ) dut (
        .clk40(clk40), .reset_n(reset_n), .enable(enable), .sink(sink),
        .fft_ready(fft_ready), .fft_valid(fft_valid), .fft_sop(fft_sop),
        .fft_eop(fft_eop), .fft_dataA(fft_dataA), .fft_dataB(fft_dataB),
        .fft_pair(fft_pair), .res_valid(res_valid), .res_eop(res_eop),
        .busy(busy), .frame_cnt(frame_cnt), .miss_cnt(miss_cnt),
        .abort_cnt(abort_cnt)
`ifdef PR3_SCHED_TIMEOUT_EN
        , .timeout_cnt(timeout_cnt)
`endif
    );

    always #5 clk40 = ~clk40;

    always @(posedge clk40) cyc <= cyc + 1;

    // ch0 ramps, ch1 = ramp+100, ch2 = -ramp; updated away from the sampling edge
    initial begin
        neg  = 14'd0;
        sink = '0;
        forever begin
            @(negedge clk40);
            ramp = ramp + 14'd1;
            neg  = 14'd0 - ramp;
            sink = {neg, ramp + 14'd100, ramp};
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(output int t);
        int n;
        n = 0;
        while (!busy && n < 250) begin
            @(negedge clk40);
            n++;
        end
        chk("busy_start_in_time", 32'(n < 250), 32'd1);
        t = cyc;
    endtask

    // res_delay < 0: no result is returned and the watchdog must end the frame
    task automatic do_frame(input int pair, input int abort_at,
                            input int res_delay, output int tstart);
        int b;
        logic done;
        logic exp_eop;
        logic [13:0] a0;
        logic [13:0] expb;
        wait_busy(tstart);
        chk("pair", 32'(fft_pair), 32'(pair));
        @(negedge clk40);
        chk("arm_no_valid", 32'(fft_valid), 32'd0);
        @(negedge clk40);
        a0 = fft_dataA;
        b = 0;
        done = 1'b0;
        while (!done && b < 16) begin
            exp_eop = (b == 15) || (b == abort_at);
            chk("beat_valid", 32'(fft_valid), 32'd1);
            chk("beat_sop", 32'(fft_sop), 32'(b == 0));
            chk("beat_eop", 32'(fft_eop), 32'(exp_eop));
            chk("dataA_ramp", 32'(fft_dataA), 32'(a0 + 14'(b)));
            expb = (pair == 2) ? 14'd0 - fft_dataA : fft_dataA + 14'd100;
            chk("dataB", 32'(fft_dataB), 32'(expb));
            done = fft_eop;
            if (b == abort_at - 1) fft_ready = 1'b0;
            b++;
            if (!done) @(negedge clk40);
        end
        chk("beat_count", 32'(b), 32'((abort_at >= 0) ? abort_at + 1 : 16));
        fft_ready = 1'b1;
        @(negedge clk40);
        chk("valid_after_eop", 32'(fft_valid), 32'd0);
        if (abort_at >= 0) begin
            chk("abort_idle", 32'(busy), 32'd0);
        end else if (res_delay < 0) begin
            b = 0;
            while (busy && b < 150) begin
                @(negedge clk40);
                b++;
            end
            chk("watchdog_idle", 32'(busy), 32'd0);
        end else begin
            res_valid = 1'b1;
            res_eop   = 1'b0;
            @(negedge clk40);
            res_valid = 1'b0;
            chk("res_no_eop_ignored", 32'(busy), 32'd1);
            repeat (res_delay - 2) @(negedge clk40);
            res_valid = 1'b1;
            res_eop   = 1'b1;
            @(negedge clk40);
            res_valid = 1'b0;
            res_eop   = 1'b0;
            chk("res_eop_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int t0, ts, tp, nb;

        repeat (3) @(negedge clk40);
        chk("rst_valid", 32'(fft_valid), 32'd0);
        chk("rst_sop_eop", 32'({fft_sop, fft_eop}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pair", 32'(fft_pair), 32'd1);
        chk("rst_counters", {frame_cnt, miss_cnt}, 32'd0);
        chk("rst_abort", 32'(abort_cnt), 32'd0);

        reset_n = 1'b1;
        t0 = cyc;

        // normal rotation 1,2,1,2
        do_frame(1, -1, 20, ts);
        chk("first_start_latency", 32'(ts - t0), 32'd100);
        tp = ts;
        do_frame(2, -1, 20, ts);
        chk("period_f2", 32'(ts - tp), 32'd100);
        tp = ts;
        do_frame(1, -1, 20, ts);
        chk("period_f3", 32'(ts - tp), 32'd100);
        tp = ts;
        do_frame(2, -1, 20, ts);
        chk("period_f4", 32'(ts - tp), 32'd100);
        tp = ts;
        chk("frame_cnt_4", 32'(frame_cnt), 32'd4);
        chk("miss_cnt_0", 32'(miss_cnt), 32'd0);

        // backpressure: ready dropped for beat 7
        do_frame(1, 7, 20, ts);
        chk("period_abort", 32'(ts - tp), 32'd100);
        tp = ts;
        chk("abort_cnt_1", 32'(abort_cnt), 32'd1);
        chk("frame_cnt_abort", 32'(frame_cnt), 32'd4);
        do_frame(1, -1, 20, ts);
        chk("period_retry", 32'(ts - tp), 32'd100);
        tp = ts;
        chk("frame_cnt_5", 32'(frame_cnt), 32'd5);

`ifdef PR3_SCHED_TIMEOUT_EN
        // late result: the watchdog ends the frame first
        do_frame(2, -1, -1, ts);
        chk("period_slow", 32'(ts - tp), 32'd100);
        tp = ts;
        chk("timeout_cnt_1", 32'(timeout_cnt), 32'd1);
        chk("frame_cnt_timeout", 32'(frame_cnt), 32'd5);
        do_frame(1, -1, 20, ts);
        chk("period_after_timeout", 32'(ts - tp), 32'd100);
        chk("miss_cnt_none", 32'(miss_cnt), 32'd0);
`else
        // late result: one tick lost, next frame on the following tick
        do_frame(2, -1, 150, ts);
        chk("period_slow", 32'(ts - tp), 32'd100);
        tp = ts;
        chk("miss_cnt_1", 32'(miss_cnt), 32'd1);
        chk("frame_cnt_6", 32'(frame_cnt), 32'd6);
        do_frame(1, -1, 20, ts);
        chk("period_after_miss", 32'(ts - tp), 32'd200);
        chk("miss_cnt_still_1", 32'(miss_cnt), 32'd1);
`endif

        // async reset in the middle of a packet
        wait_busy(ts);
        nb = 0;
        while (!fft_valid && nb < 10) begin
            @(negedge clk40);
            nb++;
        end
        chk("stream_reached", 32'(fft_valid), 32'd1);
        repeat (3) @(negedge clk40);
        @(posedge clk40);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(fft_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_pair", 32'(fft_pair), 32'd1);
        chk("arst_counters", {frame_cnt, miss_cnt}, 32'd0);
        chk("arst_abort", 32'(abort_cnt), 32'd0);
        @(negedge clk40);
        reset_n = 1'b1;
        t0 = cyc;
        do_frame(1, -1, 20, ts);
        chk("arst_restart_latency", 32'(ts - t0), 32'd100);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd1);

        // enable low across three ticks
        enable = 1'b0;
        nb = 0;
        repeat (320) begin
            @(negedge clk40);
            if (busy || fft_valid) nb++;
        end
        chk("disabled_no_activity", 32'(nb), 32'd0);
        chk("disabled_no_miss", 32'(miss_cnt), 32'd0);
        enable = 1'b1;
        do_frame(2, -1, 20, ts);
        chk("reenable_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("reenable_miss", 32'(miss_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
